// File: rtl/servo_pkg.sv
// Shared constants and types for the hobby-servo PWM driver.
package servo_pkg;

    localparam int FRAME_US = 20000;
    localparam int MIN_US   = 1000;
    localparam int MAX_US   = 2000;
    localparam int POS_W    = 6;

    typedef logic [POS_W-1:0] pos_t;

    // Microseconds per position code, truncated.
    function automatic int step_us(input int min_us, input int max_us,
                                   input int pos_w);
        return (max_us - min_us) / ((1 << pos_w) - 1);
    endfunction

endpackage

// File: rtl/us_timebase.sv
// Microsecond prescaler and frame counter; fb marks the frame boundary.
module us_timebase #(
    parameter int TPU      = 50,
    parameter int FRAME_US = 20000,
    localparam int PW      = (TPU > 1) ? $clog2(TPU) : 1,
    localparam int UW      = (FRAME_US > 1) ? $clog2(FRAME_US) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          us_tick_o,
    output logic [UW-1:0] us_cnt_o,
    output logic          fb_o
);

    localparam logic [PW-1:0] PSC_MAX = PW'(TPU - 1);
    localparam logic [UW-1:0] US_MAX  = UW'(FRAME_US - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [UW-1:0] us_q, us_d;

    always_comb begin
        us_tick_o = (psc_q == PSC_MAX);
        psc_d     = us_tick_o ? '0 : psc_q + PW'(1);
        us_d      = us_q;
        if (us_tick_o) begin
            us_d = (us_q == US_MAX) ? '0 : us_q + UW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_q <= '0;
            us_q  <= '0;
        end else begin
            psc_q <= psc_d;
            us_q  <= us_d;
        end
    end

    assign us_cnt_o = us_q;
    assign fb_o     = (psc_q == '0) && (us_q == '0);

endmodule

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator: per-frame target latch, slew limit, pulse timing.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int FRAME_US  = servo_pkg::FRAME_US,
    parameter int MIN_US    = servo_pkg::MIN_US,
    parameter int MAX_US    = servo_pkg::MAX_US,
    parameter int POS_W     = servo_pkg::POS_W,
    parameter int SLEW_STEP = 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             enable,
    input  logic [POS_W-1:0] position,
    output logic             pwm_out,
    output logic             frame_tick,
    output logic [POS_W-1:0] cur_pos,
    output logic             at_target
);

    localparam int TPU     = CLK_HZ / 1000000;
    localparam int STEP_US = step_us(MIN_US, MAX_US, POS_W);
    localparam int POS_MAX = (1 << POS_W) - 1;
    localparam int MAXW_US = MIN_US + POS_MAX * STEP_US;
    localparam int UW      = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int SLEW_C  = (SLEW_STEP > POS_MAX) ? POS_MAX : SLEW_STEP;
    localparam logic [POS_W-1:0] SLEW_V = POS_W'(SLEW_C);

    if ((CLK_HZ % 1000000) != 0 || TPU < 1) begin : g_bad_clk
        $error("CLK_HZ must be a nonzero multiple of 1 MHz");
    end
    if (MAXW_US >= FRAME_US || MIN_US < 1) begin : g_bad_width
        $error("full-scale pulse width must be shorter than the frame");
    end

    logic             us_tick;
    logic             fb;
    logic [UW-1:0]    us_cnt;
    logic [POS_W-1:0] cur_q, cur_d, tgt_q;
    logic [POS_W-1:0] diff, step;
    logic             up;
    logic [UW-1:0]    wid_q, wid_d;
    logic             pwm_q, pwm_d;
    logic             end_q, end_d;
    logic             ft_q;

    us_timebase #(
        .TPU      (TPU),
        .FRAME_US (FRAME_US)
    ) u_timebase (
        .clk_i     (clk_clk),
        .rst_i     (reset_reset),
        .us_tick_o (us_tick),
        .us_cnt_o  (us_cnt),
        .fb_o      (fb)
    );

    // wid holds width_us-1 so the last microsecond of the pulse is a match.
    always_comb begin
        up    = (position > cur_q);
        diff  = up ? position - cur_q : cur_q - position;
        step  = (SLEW_V == '0 || diff < SLEW_V) ? diff : SLEW_V;
        cur_d = up ? cur_q + step : cur_q - step;
        wid_d = UW'(MIN_US - 1 + int'(cur_d) * STEP_US);
        end_d = us_tick && (us_cnt == (fb ? wid_d : wid_q));
        pwm_d = fb ? enable : (pwm_q && !end_q);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cur_q <= '0;
            tgt_q <= '0;
            wid_q <= '0;
            pwm_q <= 1'b0;
            end_q <= 1'b0;
            ft_q  <= 1'b0;
        end else begin
            ft_q  <= fb;
            pwm_q <= pwm_d;
            end_q <= end_d;
            if (fb) begin
                tgt_q <= position;
                cur_q <= cur_d;
                wid_q <= wid_d;
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign frame_tick = ft_q;
    assign cur_pos    = cur_q;
    assign at_target  = (cur_q == tgt_q);

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Frame-level scoreboard bench for servo_pwm_driver (unlimited and 4-code slew).
module tb_servo_pwm_driver;

    localparam int FRAME_CYC = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sel;
    logic [5:0] pos;

    logic       pwm0, ft0, at0;
    logic       pwm4, ft4, at4;
    logic [5:0] cur0, cur4;

    logic       m_pwm, m_ft, m_at;
    logic [5:0] m_cur;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] cur;
        logic [31:0] at;
        logic [31:0] wid;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    servo_pwm_driver #(
        .CLK_HZ    (2000000),
        .FRAME_US  (2000),
        .SLEW_STEP (0)
    ) u_dut0 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .enable      (en),
        .position    (pos),
        .pwm_out     (pwm0),
        .frame_tick  (ft0),
        .cur_pos     (cur0),
        .at_target   (at0)
    );

    servo_pwm_driver #(
        .CLK_HZ    (2000000),
        .FRAME_US  (2000),
        .SLEW_STEP (4)
    ) u_dut4 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .enable      (en),
        .position    (pos),
        .pwm_out     (pwm4),
        .frame_tick  (ft4),
        .cur_pos     (cur4),
        .at_target   (at4)
    );

    assign m_pwm = sel ? pwm4 : pwm0;
    assign m_ft  = sel ? ft4  : ft0;
    assign m_at  = sel ? at4  : at0;
    assign m_cur = sel ? cur4 : cur0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input int a, input int w);
        exp_t e;
        e.cur = c;
        e.at  = a;
        e.wid = w;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ft();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME_CYC + 100; i++) begin
            @(negedge clk);
            if (m_ft) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ft_seen", {31'd0, seen}, 1);
    endtask

    // Frame monitor: measures each frame from frame_tick to frame_tick.
    initial begin
        logic        in_fr;
        logic [31:0] f_cur, f_at;
        int          hi, per;
        exp_t        e;
        in_fr = 1'b0;
        hi    = 0;
        per   = 0;
        f_cur = '0;
        f_at  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                in_fr = 1'b0;
            end else if (m_ft) begin
                if (in_fr && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("frame_cur", f_cur, e.cur);
                    chk("frame_at", f_at, e.at);
                    chk("frame_width", hi, e.wid);
                    chk("frame_period", per, FRAME_CYC);
                end
                in_fr = 1'b1;
                f_cur = {26'd0, m_cur};
                f_at  = {31'd0, m_at};
                hi    = m_pwm ? 1 : 0;
                per   = 1;
            end else if (in_fr) begin
                per++;
                hi += m_pwm ? 1 : 0;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b1;
        pos = 6'd0;
        sel = 1'b0;
        wait_cyc(3);
        chk("rst_pwm", {31'd0, pwm0}, 0);
        chk("rst_ft", {31'd0, ft0}, 0);
        chk("rst_cur", {26'd0, cur0}, 0);
        chk("rst_at", {31'd0, at0}, 1);
        rst = 1'b0;

        wait_ft();
        push(0, 1, 2000);
        wait_ft();
        push(0, 1, 2000);
        wait_cyc(2500);
        pos = 6'd63;

        wait_ft();
        push(63, 1, 3890);
        chk("slew4_cur_f3", {26'd0, cur4}, 4);
        chk("slew4_at_f3", {31'd0, at4}, 0);
        wait_cyc(100);
        pos = 6'd40;
        wait_cyc(900);
        pos = 6'd0;
        wait_cyc(1000);
        pos = 6'd40;

        wait_ft();
        push(40, 1, 3200);
        wait_cyc(100);
        pos = 6'd0;
        wait_cyc(400);
        pos = 6'd40;
        wait_cyc(2500);
        pos = 6'd0;

        wait_ft();
        push(0, 1, 2000);
        wait_cyc(500);
        en = 1'b0;

        wait_ft();
        push(0, 1, 0);
        wait_cyc(1000);
        en = 1'b1;

        wait_ft();
        push(0, 1, 2000);
        wait_cyc(2500);
        pos = 6'd10;

        wait_ft();
        wait_cyc(100);
        chk("pre_rst_pwm", {31'd0, pwm0}, 1);
        chk("pre_rst_cur", {26'd0, cur0}, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pwm", {31'd0, pwm0}, 0);
        chk("midrst_cur", {26'd0, cur0}, 0);
        chk("midrst_cur4", {26'd0, cur4}, 0);
        chk("midrst_ft", {31'd0, ft0}, 0);
        rst = 1'b0;
        sel = 1'b1;

        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (m_ft) break;
        end
        chk("rst_ft_latency", n, 1);
        push(4, 0, 2120);
        wait_ft();
        push(8, 0, 2240);
        wait_ft();
        push(10, 1, 2300);
        wait_ft();
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
